// File: rtl/ifd_pkg.sv
// rtl/ifd_pkg.sv - shared definitions for the instruction fetch/decode front end
// Contents: opcode codes (also the ALU select codes used by the datapath),
// FSM state encoding, instruction field positions, default widths and the
// decoded-control record passed from inst_decoder to its parent.
package ifd_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  // Instruction field positions; imm8 overlaps ra/rb.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RA_LSB  = 6;
  localparam int RB_LSB  = 3;
  localparam int IMM_MSB = 7;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] imm8;
    logic       wr_en;
    logic       mem_rd;
    logic       mem_wr;
    logic       jmp;
    logic       bz;
  } dec_ctrl_t;

  // Opcodes A..E have no defined meaning.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/inst_fetch_decode_decoder.sv
// rtl/inst_fetch_decode_decoder.sv - combinational instruction decoder (module inst_decoder)
// Ports:
//   ir    in  16          instruction register
//   ctrl  out dec_ctrl_t  register addresses, imm8, ALU select and controls
// Illegal opcodes come out as a NOP with every control low.
module inst_decoder
  import ifd_pkg::*;
(
  input  logic [15:0] ir,
  output dec_ctrl_t   ctrl
);

  logic [3:0] op;
  assign op = ir[OP_MSB:OP_LSB];

  always_comb begin
    ctrl      = '0;
    ctrl.op   = op;
    ctrl.rd   = ir[RD_LSB +: 3];
    ctrl.ra   = ir[RA_LSB +: 3];
    ctrl.rb   = ir[RB_LSB +: 3];
    ctrl.imm8 = ir[IMM_MSB:0];
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI: ctrl.wr_en = 1'b1;
      OP_LD: begin
        ctrl.wr_en  = 1'b1;
        ctrl.mem_rd = 1'b1;
      end
      OP_ST:           ctrl.mem_wr = 1'b1;
      OP_JMP:          ctrl.jmp    = 1'b1;
      OP_BZ:           ctrl.bz     = 1'b1;
      OP_NOP, OP_HALT: ctrl.op     = op;
      default:         ctrl.op     = OP_NOP;
    endcase
  end

endmodule

// File: rtl/inst_fetch_decode.sv
// rtl/inst_fetch_decode.sv - PC, instruction fetch, decode and issue to the datapath
// Optional macro: IFD_ILLEGAL_TRAP_EN (opcodes A..E halt the core and report trap_pc).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata        instruction fetch handshake (req held until ack)
//   dec_valid/dec_ready            issue handshake towards the datapath
//   dec_pc, dec_op, dec_rd/ra/rb   issued instruction address, ALU select, registers
//   dec_imm                        sign-extended imm8
//   dec_wr_en, dec_mem_rd/wr       register write, load, store
//   dec_jmp, dec_bz                jump, branch-if-zero
//   br_valid, br_target            redirect from the datapath
//   halted                         HALT reached
//   illegal, trap_pc               (macro only) illegal-opcode trap and its address
module inst_fetch_decode
  import ifd_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [3:0]        dec_op,
  output logic [2:0]        dec_rd,
  output logic [2:0]        dec_ra,
  output logic [2:0]        dec_rb,
  output logic [DATA_W-1:0] dec_imm,
  output logic              dec_wr_en,
  output logic              dec_mem_rd,
  output logic              dec_mem_wr,
  output logic              dec_jmp,
  output logic              dec_bz,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              halted
`ifdef IFD_ILLEGAL_TRAP_EN
  ,
  output logic              illegal,
  output logic [ADDR_W-1:0] trap_pc
`endif
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ir_pc;  // address the word in ir was fetched from
  logic [DATA_W-1:0] ir;
  dec_ctrl_t         ctrl;

  assign imem_addr = pc;

  inst_decoder u_decoder (
    .ir   (ir[15:0]),
    .ctrl (ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      ir_pc      <= RESET_PC;
      ir         <= '0;
      imem_req   <= 1'b0;
      dec_valid  <= 1'b0;
      dec_pc     <= '0;
      dec_op     <= '0;
      dec_rd     <= '0;
      dec_ra     <= '0;
      dec_rb     <= '0;
      dec_imm    <= '0;
      dec_wr_en  <= 1'b0;
      dec_mem_rd <= 1'b0;
      dec_mem_wr <= 1'b0;
      dec_jmp    <= 1'b0;
      dec_bz     <= 1'b0;
      halted     <= 1'b0;
`ifdef IFD_ILLEGAL_TRAP_EN
      illegal    <= 1'b0;
      trap_pc    <= '0;
`endif
    end else if (br_valid && state != ST_HALT) begin
      // Redirect beats any concurrent ack or issue handshake. The request is
      // dropped for one cycle so the memory sees a fresh request at the target.
      pc        <= br_target;
      ir        <= '0;
      dec_valid <= 1'b0;
      imem_req  <= 1'b0;
      state     <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            ir_pc    <= pc;
            pc       <= pc + ADDR_W'(1);
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
`ifdef IFD_ILLEGAL_TRAP_EN
          if (is_illegal(ir[OP_MSB:OP_LSB])) begin
            illegal <= 1'b1;
            trap_pc <= ir_pc;
            halted  <= 1'b1;
            state   <= ST_HALT;
          end else
`endif
          begin
            dec_pc     <= ir_pc;
            dec_op     <= ctrl.op;
            dec_rd     <= ctrl.rd;
            dec_ra     <= ctrl.ra;
            dec_rb     <= ctrl.rb;
            dec_imm    <= {{(DATA_W-8){ctrl.imm8[7]}}, ctrl.imm8};
            dec_wr_en  <= ctrl.wr_en;
            dec_mem_rd <= ctrl.mem_rd;
            dec_mem_wr <= ctrl.mem_wr;
            dec_jmp    <= ctrl.jmp;
            dec_bz     <= ctrl.bz;
            dec_valid  <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dec_ready) begin
            dec_valid <= 1'b0;
            if (dec_op == OP_HALT) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else begin
              // Raise the next request right away: 3 cycles per instruction.
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          imem_req  <= 1'b0;
          dec_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
